// File: rtl/isa_slave_pkg.sv
// Shared types and helpers for the ISA slave cycle engine: FSM states, widths, lane decode.
package isa_slave_pkg;

  typedef enum logic [2:0] {
    StIdle, StArm, StCapt, StDec, StAct, StWack, StHold, StRel
  } state_e;

  localparam int unsigned WinIdxW = 3;
  localparam int unsigned IoAddrW = 16;

  typedef struct packed {
    logic [3:0] te;  // active-low transceiver enables
    logic [1:0] be;  // {hi, lo}
  } lane_t;

  // Steering of data lanes from SBHE and A0 (both as seen on the bus).
  function automatic lane_t lane_decode(input logic sbhe, input logic a0);
    lane_t l;
    unique case ({sbhe, a0})
      2'b00:   l = '{te: 4'b1100, be: 2'b11};
      2'b01:   l = '{te: 4'b0011, be: 2'b11};
      2'b10:   l = '{te: 4'b1110, be: 2'b01};
      default: l = '{te: 4'b0111, be: 2'b10};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/isa_sync_bus.sv
// Multi-bit, multi-stage synchroniser for asynchronous ISA control inputs.
module isa_sync_bus #(
  parameter int unsigned         Width    = 1,
  parameter int unsigned         Stages   = 2,
  parameter logic [Width-1:0]    ResetVal = '0
) (
  input  logic             FPGACLK,
  input  logic             RESET,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage_q [Stages];

  always_ff @(posedge FPGACLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(Stages); i++) stage_q[i] <= ResetVal;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(Stages); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[Stages-1];

endmodule

// File: rtl/isa_slave_cycle_engine.sv
// ISA slave: window decode, bus-cycle sequencing and backend req/ack handoff.
// Optional host wait-state handshake enabled by defining ISA_SLAVE_WAIT_STATES_EN.
module isa_slave_cycle_engine
  import isa_slave_pkg::*;
#(
  parameter int unsigned               NUM_MEM_WIN  = 2,
  parameter logic [NUM_MEM_WIN*20-1:0] MEM_BASE     = {20'hB8000, 20'hA0000},
  parameter logic [NUM_MEM_WIN*20-1:0] MEM_LIMIT    = {20'hBFFFF, 20'hAFFFF},
  parameter logic [15:0]               IO_BASE      = 16'h0420,
  parameter logic [15:0]               IO_LIMIT     = 16'h0430,
  parameter int unsigned               SYNC_STAGES  = 2,
  parameter int unsigned               TIMEOUT_CLKS = 64
) (
  input  logic                   FPGACLK,
  input  logic                   RESET,
  input  logic [19:0]            addressBus,
  input  logic                   BALE,
  input  logic                   SBHE,
  input  logic                   MEMR,
  input  logic                   MEMW,
  input  logic                   SMEMR,
  input  logic                   SMEMW,
  input  logic                   IOR,
  input  logic                   IOW,
  input  logic [NUM_MEM_WIN:0]   win_en,
  output logic                   ADS_LATCH,
  output logic                   ADS_OE,
  output logic                   FPGA_IO_EN,
  output logic                   IOCS16,
  output logic                   MEMCS16,
  output logic                   NOWS,
  output logic                   IO_RDY,
  output logic                   IOERR,
  output logic [3:0]             TE,
  output logic                   FPGA_WR,
  output logic                   req,
  output logic [19:0]            req_addr,
  output logic [WinIdxW-1:0]     req_win,
  output logic [1:0]             req_be,
  input  logic                   ack,
  output logic                   err_timeout
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS);

  logic [6:0] sync_in, sync_out;
  assign sync_in = {BALE, MEMR, MEMW, SMEMR, SMEMW, IOR, IOW};

  isa_sync_bus #(
    .Width   (7),
    .Stages  (SYNC_STAGES),
    .ResetVal(7'b0111111)
  ) u_sync (
    .FPGACLK(FPGACLK),
    .RESET  (RESET),
    .d      (sync_in),
    .q      (sync_out)
  );

  logic bale_s, mem_rd_s, mem_wr_s, io_rd_s, io_wr_s, strobe_any;
  assign bale_s     = sync_out[6];
  assign mem_rd_s   = ~sync_out[5] | ~sync_out[3];
  assign mem_wr_s   = ~sync_out[4] | ~sync_out[2];
  assign io_rd_s    = ~sync_out[1];
  assign io_wr_s    = ~sync_out[0];
  assign strobe_any = |(~sync_out[5:0]);

  state_e              state_q, state_d;
  logic [2:0]          arm_cnt_q, arm_cnt_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                tmo_fire;
  logic [19:0]         addr_q;
  logic                sbhe_q, is_mem_q, is_io_q, fpga_wr_q;
  logic [WinIdxW-1:0]  win_q, hit_win;
  logic [1:0]          be_q;
  logic [3:0]          te_q;
  logic                ads_oe_q, memcs16_q, iocs16_q, req_q, err_timeout_q, hit;
  lane_t               lane;

  assign lane = lane_decode(sbhe_q, addr_q[0]);

  // Lowest index wins: scan downwards so the last assignment is the smallest hit.
  always_comb begin
    hit     = 1'b0;
    hit_win = '0;
    if (is_mem_q && !is_io_q) begin
      for (int i = int'(NUM_MEM_WIN) - 1; i >= 0; i--) begin
        if (win_en[i] && addr_q >= MEM_BASE[i*20 +: 20] && addr_q <= MEM_LIMIT[i*20 +: 20]) begin
          hit     = 1'b1;
          hit_win = WinIdxW'(i);
        end
      end
    end else if (is_io_q && !is_mem_q) begin
      if (win_en[NUM_MEM_WIN] && addr_q[19:IoAddrW] == '0 &&
          addr_q[IoAddrW-1:0] >= IO_BASE && addr_q[IoAddrW-1:0] <= IO_LIMIT) begin
        hit     = 1'b1;
        hit_win = WinIdxW'(NUM_MEM_WIN);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_fire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        arm_cnt_d = '0;
        if (bale_s) state_d = StArm;
      end
      StArm: begin
        if (strobe_any) begin
          state_d = StCapt;
        end else if (!bale_s) begin
          arm_cnt_d = arm_cnt_q + 3'd1;
          if (arm_cnt_q == 3'd7) state_d = StRel;
        end
      end
      StCapt: state_d = StDec;
      StDec:  state_d = hit ? StAct : StRel;
      StAct: begin
        tmo_cnt_d = TmoW'(1);
        state_d   = ack ? StHold : StWack;
      end
      StWack: begin
        if (ack) begin
          state_d = StHold;
        end else if (tmo_cnt_q == TmoW'(TIMEOUT_CLKS - 1)) begin
          state_d  = StHold;
          tmo_fire = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StHold: if (!strobe_any) state_d = StRel;
      StRel: begin
        arm_cnt_d = '0;
        state_d   = bale_s ? StArm : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge FPGACLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= StIdle;
      arm_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      addr_q        <= '0;
      sbhe_q        <= 1'b1;
      is_mem_q      <= 1'b0;
      is_io_q       <= 1'b0;
      fpga_wr_q     <= 1'b0;
      win_q         <= '0;
      be_q          <= '0;
      te_q          <= 4'hF;
      ads_oe_q      <= 1'b1;
      memcs16_q     <= 1'b0;
      iocs16_q      <= 1'b0;
      req_q         <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      req_q         <= (state_d == StAct);
      err_timeout_q <= tmo_fire;
      if (state_d == StArm) ads_oe_q <= 1'b0;
      if (state_d == StRel) begin
        ads_oe_q  <= 1'b1;
        te_q      <= 4'hF;
        memcs16_q <= 1'b0;
        iocs16_q  <= 1'b0;
      end
      if (state_q == StCapt) begin
        addr_q    <= addressBus;
        sbhe_q    <= SBHE;
        is_mem_q  <= mem_rd_s | mem_wr_s;
        is_io_q   <= io_rd_s | io_wr_s;
        fpga_wr_q <= mem_rd_s | io_rd_s;
      end
      if (state_q == StDec && hit) begin
        win_q     <= hit_win;
        be_q      <= lane.be;
        te_q      <= lane.te;
        memcs16_q <= ~sbhe_q & is_mem_q;
        iocs16_q  <= ~sbhe_q & is_io_q;
      end
    end
  end

`ifdef ISA_SLAVE_WAIT_STATES_EN
  logic io_rdy_q, ioerr_q;

  always_ff @(posedge FPGACLK or negedge RESET) begin
    if (!RESET) begin
      io_rdy_q <= 1'b1;
      ioerr_q  <= 1'b1;
    end else begin
      ioerr_q <= ~tmo_fire;
      if (state_d == StAct)       io_rdy_q <= 1'b0;
      else if (state_d == StHold) io_rdy_q <= 1'b1;
    end
  end

  assign NOWS   = 1'b1;
  assign IO_RDY = io_rdy_q;
  assign IOERR  = ioerr_q;
`else
  assign NOWS   = 1'b0;
  assign IO_RDY = 1'b1;
  assign IOERR  = 1'b1;
`endif

  assign ADS_LATCH   = BALE;
  assign ADS_OE      = ads_oe_q;
  assign FPGA_IO_EN  = (state_q != StIdle) | BALE;
  assign IOCS16      = iocs16_q;
  assign MEMCS16     = memcs16_q;
  assign TE          = te_q;
  assign FPGA_WR     = fpga_wr_q;
  assign req         = req_q;
  assign req_addr    = addr_q;
  assign req_win     = win_q;
  assign req_be      = be_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_isa_slave_cycle_engine.sv
// Scoreboard bench for isa_slave_cycle_engine: directed ISA cycles, monitor checks each req.
module tb_isa_slave_cycle_engine;

  localparam int SMemr = 0, SMemw = 1, SSmemr = 2, SSmemw = 3, SIor = 4, SIow = 5;

  logic        FPGACLK = 1'b0;
  logic        RESET;
  logic [19:0] addressBus;
  logic        BALE, SBHE, MEMR, MEMW, SMEMR, SMEMW, IOR, IOW;
  logic [2:0]  win_en;
  logic        ADS_LATCH, ADS_OE, FPGA_IO_EN, IOCS16, MEMCS16, NOWS, IO_RDY, IOERR;
  logic [3:0]  TE;
  logic        FPGA_WR, req, ack, err_timeout;
  logic [19:0] req_addr;
  logic [2:0]  req_win;
  logic [1:0]  req_be;

  isa_slave_cycle_engine dut (
    .FPGACLK(FPGACLK), .RESET(RESET), .addressBus(addressBus), .BALE(BALE), .SBHE(SBHE),
    .MEMR(MEMR), .MEMW(MEMW), .SMEMR(SMEMR), .SMEMW(SMEMW), .IOR(IOR), .IOW(IOW),
    .win_en(win_en), .ADS_LATCH(ADS_LATCH), .ADS_OE(ADS_OE), .FPGA_IO_EN(FPGA_IO_EN),
    .IOCS16(IOCS16), .MEMCS16(MEMCS16), .NOWS(NOWS), .IO_RDY(IO_RDY), .IOERR(IOERR),
    .TE(TE), .FPGA_WR(FPGA_WR), .req(req), .req_addr(req_addr), .req_win(req_win),
    .req_be(req_be), .ack(ack), .err_timeout(err_timeout)
  );

  always #5 FPGACLK = ~FPGACLK;

  typedef struct {
    logic [19:0] addr;
    logic [2:0]  win;
    logic [1:0]  be;
    logic [3:0]  te;
    logic        wr;
    logic        memcs;
    logic        iocs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   failures = 0;
  int   ack_delay = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_req(input logic [19:0] a, input logic [2:0] w, input logic [1:0] be,
                            input logic [3:0] te, input logic wr, input logic mcs, input logic ics);
    exp_t e;
    e.addr = a; e.win = w; e.be = be; e.te = te; e.wr = wr; e.memcs = mcs; e.iocs = ics;
    exp_q.push_back(e);
  endtask

  // Monitor: every req pulse must match the oldest expectation.
  always @(negedge FPGACLK) begin
    if (RESET === 1'b1 && req === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req", {12'h0, req_addr}, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("req_addr", {12'h0, req_addr}, {12'h0, e.addr});
        check("req_win", {29'h0, req_win}, {29'h0, e.win});
        check("req_be", {30'h0, req_be}, {30'h0, e.be});
        check("TE", {28'h0, TE}, {28'h0, e.te});
        check("FPGA_WR", {31'h0, FPGA_WR}, {31'h0, e.wr});
        check("MEMCS16", {31'h0, MEMCS16}, {31'h0, e.memcs});
        check("IOCS16", {31'h0, IOCS16}, {31'h0, e.iocs});
      end
    end
  end

  // Backend model: ack ack_delay clocks after req; negative delay withholds ack.
  initial begin
    ack = 1'b0;
    forever begin
      @(negedge FPGACLK);
      if (RESET === 1'b1 && req === 1'b1 && ack_delay >= 0) begin
        repeat (ack_delay) @(posedge FPGACLK);
        #1 ack = 1'b1;
        @(posedge FPGACLK);
        #1 ack = 1'b0;
      end
    end
  end

  task automatic set_strobe(input int s);
    case (s)
      SMemr:   MEMR  = 1'b0;
      SMemw:   MEMW  = 1'b0;
      SSmemr:  SMEMR = 1'b0;
      SSmemw:  SMEMW = 1'b0;
      SIor:    IOR   = 1'b0;
      default: IOW   = 1'b0;
    endcase
  endtask

  task automatic release_strobes();
    {MEMR, MEMW, SMEMR, SMEMW, IOR, IOW} = 6'h3F;
    SBHE = 1'b1;
  endtask

  // One ISA cycle: BALE for 2 clks, then strobe held for 'hold' clks. 'miss' adds release checks.
  task automatic isa_cycle(input logic [19:0] a, input logic sbhe, input int s, input int hold,
                           input bit miss);
    @(posedge FPGACLK); #1;
    addressBus = a; SBHE = sbhe; BALE = 1'b1;
    @(negedge FPGACLK);
    check("ADS_LATCH", {31'h0, ADS_LATCH}, 32'h1);
    check("FPGA_IO_EN_bale", {31'h0, FPGA_IO_EN}, 32'h1);
    repeat (2) @(posedge FPGACLK);
    #1 BALE = 1'b0;
    set_strobe(s);
    for (int c = 0; c < hold; c++) begin
      @(negedge FPGACLK);
      if (miss && c == 1) check("ADS_OE_armed", {31'h0, ADS_OE}, 32'h0);
      if (miss && c == 6) begin
        check("ADS_OE_released", {31'h0, ADS_OE}, 32'h1);
        check("TE_miss", {28'h0, TE}, 32'hF);
        check("FPGA_IO_EN_idle", {31'h0, FPGA_IO_EN}, 32'h0);
      end
    end
    @(posedge FPGACLK); #1;
    release_strobes();
    repeat (6) @(posedge FPGACLK);
  endtask

  task automatic wait_req(input int bound, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      @(negedge FPGACLK);
      if (req === 1'b1) seen = 1'b1;
    end
    if (!seen) check("req_wait_expired", 32'h0, 32'h1);
  endtask

  initial begin
    bit seen;
    int cnt;
    bit rdy_bad;
    RESET = 1'b0; BALE = 1'b0; addressBus = '0; win_en = 3'b111;
    release_strobes();
    #22;
    check("rst_ADS_OE", {31'h0, ADS_OE}, 32'h1);
    check("rst_TE", {28'h0, TE}, 32'hF);
    check("rst_IOCS16", {31'h0, IOCS16}, 32'h0);
    check("rst_MEMCS16", {31'h0, MEMCS16}, 32'h0);
    check("rst_req", {31'h0, req}, 32'h0);
    check("rst_err_timeout", {31'h0, err_timeout}, 32'h0);
    check("rst_IO_RDY", {31'h0, IO_RDY}, 32'h1);
    check("rst_IOERR", {31'h0, IOERR}, 32'h1);
    check("rst_FPGA_IO_EN", {31'h0, FPGA_IO_EN}, 32'h0);
`ifdef ISA_SLAVE_WAIT_STATES_EN
    check("NOWS", {31'h0, NOWS}, 32'h1);
`else
    check("NOWS", {31'h0, NOWS}, 32'h0);
`endif
    @(posedge FPGACLK); #1 RESET = 1'b1;
    repeat (3) @(posedge FPGACLK);

    // Hits across windows and lane patterns.
    ack_delay = 5;
    expect_req(20'hA0010, 3'd0, 2'b11, 4'b1100, 1'b0, 1'b1, 1'b0);
    isa_cycle(20'hA0010, 1'b0, SMemw, 16, 1'b0);
    ack_delay = 2;
    expect_req(20'h00421, 3'd2, 2'b10, 4'b0111, 1'b1, 1'b0, 1'b0);
    isa_cycle(20'h00421, 1'b1, SIor, 12, 1'b0);
    ack_delay = 1;
    expect_req(20'h00420, 3'd2, 2'b11, 4'b1100, 1'b0, 1'b0, 1'b1);
    isa_cycle(20'h00420, 1'b0, SIow, 12, 1'b0);
    expect_req(20'hB8001, 3'd1, 2'b10, 4'b0111, 1'b1, 1'b0, 1'b0);
    isa_cycle(20'hB8001, 1'b1, SMemr, 12, 1'b0);
    expect_req(20'hBFFFF, 3'd1, 2'b11, 4'b0011, 1'b0, 1'b1, 1'b0);
    isa_cycle(20'hBFFFF, 1'b0, SSmemw, 12, 1'b0);

    // Misses: outside windows, disabled window, IO above limit / upper address bits set.
    isa_cycle(20'hC0000, 1'b1, SMemr, 12, 1'b1);
    win_en = 3'b110;
    isa_cycle(20'hA0000, 1'b1, SMemw, 12, 1'b1);
    win_en = 3'b111;
    expect_req(20'hA0000, 3'd0, 2'b01, 4'b1110, 1'b0, 1'b0, 1'b0);
    isa_cycle(20'hA0000, 1'b1, SMemw, 12, 1'b0);
    isa_cycle(20'h00431, 1'b1, SIor, 12, 1'b1);
    isa_cycle(20'h10421, 1'b1, SIor, 12, 1'b1);

    // Ack withheld: timeout after TIMEOUT_CLKS.
    ack_delay = -1;
    expect_req(20'hA0002, 3'd0, 2'b11, 4'b1100, 1'b0, 1'b1, 1'b0);
    fork
      isa_cycle(20'hA0002, 1'b0, SMemw, 80, 1'b0);
      begin
        wait_req(40, seen);
        cnt = 0;
        rdy_bad = 1'b0;
`ifdef ISA_SLAVE_WAIT_STATES_EN
        if (IO_RDY !== 1'b0) rdy_bad = 1'b1;
`endif
        while (seen && cnt < 200) begin
          @(negedge FPGACLK);
          cnt++;
          if (err_timeout === 1'b1) break;
`ifdef ISA_SLAVE_WAIT_STATES_EN
          if (IO_RDY !== 1'b0) rdy_bad = 1'b1;
`else
          if (IO_RDY !== 1'b1) rdy_bad = 1'b1;
`endif
        end
        check("timeout_latency", cnt, 64);
        check("IO_RDY_during_wait", {31'h0, rdy_bad}, 32'h0);
        check("IO_RDY_after_timeout", {31'h0, IO_RDY}, 32'h1);
`ifdef ISA_SLAVE_WAIT_STATES_EN
        check("IOERR_on_timeout", {31'h0, IOERR}, 32'h0);
`else
        check("IOERR_on_timeout", {31'h0, IOERR}, 32'h1);
`endif
        check("MEMCS16_hold", {31'h0, MEMCS16}, 32'h1);
        @(negedge FPGACLK);
        check("err_timeout_one_clk", {31'h0, err_timeout}, 32'h0);
      end
    join

    // Reset asserted while waiting for ack.
    expect_req(20'hA0010, 3'd0, 2'b11, 4'b1100, 1'b0, 1'b1, 1'b0);
    fork
      isa_cycle(20'hA0010, 1'b0, SMemw, 20, 1'b0);
      begin
        wait_req(40, seen);
        repeat (3) @(negedge FPGACLK);
        RESET = 1'b0;
        #1;
        check("wack_rst_TE", {28'h0, TE}, 32'hF);
        check("wack_rst_MEMCS16", {31'h0, MEMCS16}, 32'h0);
        check("wack_rst_ADS_OE", {31'h0, ADS_OE}, 32'h1);
        check("wack_rst_IO_RDY", {31'h0, IO_RDY}, 32'h1);
        check("wack_rst_req", {31'h0, req}, 32'h0);
        @(posedge FPGACLK); #1 RESET = 1'b1;
      end
    join
    ack_delay = 3;
    expect_req(20'hA0010, 3'd0, 2'b11, 4'b1100, 1'b0, 1'b1, 1'b0);
    isa_cycle(20'hA0010, 1'b0, SMemw, 14, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, failures);
    $finish;
  end

endmodule
